// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/sequencing controller.
// Forwarding selects, controller FSM states and the per-stage control vector.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_NO      = 2'd0,
        FWD_ALU_EXE = 2'd1,
        FWD_ALU_MEM = 2'd2,
        FWD_MEM     = 2'd3
    } fwd_e;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_STEP = 2'd3
    } state_e;

    localparam logic [4:0] GPR_ZERO = 5'd0;

    // One bit per pipeline stage, IF first.
    typedef struct packed {
        logic if_s;
        logic id_s;
        logic exe_s;
        logic mem_s;
        logic wb_s;
    } stage_vec_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Datapath-facing signal bundle of the pipeline controller.
// master = CPU/datapath side, slave = controller side.
interface pipeline_ctrl_if;

    logic        rs_used_id;
    logic        rt_used_id;
    logic [31:0] inst_data_id;
    logic [4:0]  regw_addr_exe;
    logic        wb_wen_exe;
    logic        wb_data_src_exe;
    logic [4:0]  regw_addr_mem;
    logic        wb_wen_mem;
    logic        wb_data_src_mem;
    logic        is_branch_mem;
    logic        mem_req;
    logic        mem_ack;
    logic        dbg_run;
    logic        dbg_step;

    logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic        if_en, id_en, exe_en, mem_en, wb_en;
    logic [1:0]  exe_fwd_a_ctrl;
    logic [1:0]  exe_fwd_b_ctrl;
    logic        halted;
    logic        mem_err;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        output rs_used_id, rt_used_id, inst_data_id,
        output regw_addr_exe, wb_wen_exe, wb_data_src_exe,
        output regw_addr_mem, wb_wen_mem, wb_data_src_mem,
        output is_branch_mem, mem_req, mem_ack, dbg_run, dbg_step,
        input  if_rst, id_rst, exe_rst, mem_rst, wb_rst,
        input  if_en, id_en, exe_en, mem_en, wb_en,
        input  exe_fwd_a_ctrl, exe_fwd_b_ctrl, halted, mem_err,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  rs_used_id, rt_used_id, inst_data_id,
        input  regw_addr_exe, wb_wen_exe, wb_data_src_exe,
        input  regw_addr_mem, wb_wen_mem, wb_data_src_mem,
        input  is_branch_mem, mem_req, mem_ack, dbg_run, dbg_step,
        output if_rst, id_rst, exe_rst, mem_rst, wb_rst,
        output if_en, id_en, exe_en, mem_en, wb_en,
        output exe_fwd_a_ctrl, exe_fwd_b_ctrl, halted, mem_err,
        output stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_fwd_sel.sv
// Per-operand EXE-entry forwarding select; purely combinational, zero latency.
// No backpressure: a pure function of the current ID/EXE/MEM fields.
module pipeline_ctrl_fwd_sel
    import pipeline_ctrl_pkg::*;
(
    input  logic       src_used,
    input  logic [4:0] src_addr,
    input  logic [4:0] regw_addr_exe,
    input  logic       wb_wen_exe,
    input  logic       wb_data_src_exe,
    input  logic [4:0] regw_addr_mem,
    input  logic       wb_wen_mem,
    input  logic       wb_data_src_mem,
    output fwd_e       fwd_sel
);

    // A load in EXE has no data yet, so it never selects FWD_ALU_EXE and the
    // MEM-stage check gets its chance; WB producers go through regfile write-through.
    always_comb begin
        fwd_sel = FWD_NO;
        if (!src_used || src_addr == GPR_ZERO) begin
            fwd_sel = FWD_NO;
        end else if (src_addr == regw_addr_exe && wb_wen_exe && !wb_data_src_exe) begin
            fwd_sel = FWD_ALU_EXE;
        end else if (src_addr == regw_addr_mem && wb_wen_mem) begin
            fwd_sel = wb_data_src_mem ? FWD_MEM : FWD_ALU_MEM;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// MIPS 5-stage hazard/sequencing controller; PIPE_PERF_CNT_EN adds stall/flush counters.
// Latency: stage rst/en and forwarding selects are combinational, zero added latency.
// Backpressure: an unacknowledged data-memory access freezes IF..MEM and bubbles WB.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int RST_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave pif
);

    localparam int              ICW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [ICW-1:0]  INIT_LAST = ICW'(RST_CYCLES - 1);
    localparam logic [7:0]      WAIT_MAX  = 8'(MEM_TIMEOUT);

    state_e         state_q, state_d;
    logic [ICW-1:0] init_cnt_q, init_cnt_d;
    logic [7:0]     wait_cnt_q, wait_cnt_d;
    logic           mem_err_q, mem_err_d;

    stage_vec_t     stage_rst, stage_en;
    logic           halted;
    fwd_e           fwd_a_raw, fwd_b_raw, fwd_a, fwd_b;
    logic [4:0]     rs_id, rt_id;
    logic           mem_wait, load_use, advance;

    assign rs_id    = pif.inst_data_id[25:21];
    assign rt_id    = pif.inst_data_id[20:16];
    assign mem_wait = pif.mem_req & ~pif.mem_ack;
    assign advance  = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign load_use = pif.wb_wen_exe & pif.wb_data_src_exe & (pif.regw_addr_exe != GPR_ZERO)
                    & ((pif.rs_used_id & (rs_id == pif.regw_addr_exe))
                     | (pif.rt_used_id & (rt_id == pif.regw_addr_exe)));

    pipeline_ctrl_fwd_sel u_fwd_a (
        .src_used        (pif.rs_used_id),
        .src_addr        (rs_id),
        .regw_addr_exe   (pif.regw_addr_exe),
        .wb_wen_exe      (pif.wb_wen_exe),
        .wb_data_src_exe (pif.wb_data_src_exe),
        .regw_addr_mem   (pif.regw_addr_mem),
        .wb_wen_mem      (pif.wb_wen_mem),
        .wb_data_src_mem (pif.wb_data_src_mem),
        .fwd_sel         (fwd_a_raw)
    );

    pipeline_ctrl_fwd_sel u_fwd_b (
        .src_used        (pif.rt_used_id),
        .src_addr        (rt_id),
        .regw_addr_exe   (pif.regw_addr_exe),
        .wb_wen_exe      (pif.wb_wen_exe),
        .wb_data_src_exe (pif.wb_data_src_exe),
        .regw_addr_mem   (pif.regw_addr_mem),
        .wb_wen_mem      (pif.wb_wen_mem),
        .wb_data_src_mem (pif.wb_data_src_mem),
        .fwd_sel         (fwd_b_raw)
    );

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wait_cnt_d = '0;
        mem_err_d  = mem_err_q;
        stage_rst  = '0;
        stage_en   = '0;
        halted     = 1'b0;
        fwd_a      = fwd_a_raw;
        fwd_b      = fwd_b_raw;

        case (state_q)
            ST_INIT: begin
                stage_rst = '1;
                fwd_a     = FWD_NO;
                fwd_b     = FWD_NO;
                if (init_cnt_q == INIT_LAST) begin
                    state_d = pif.dbg_run ? ST_RUN : ST_HALT;
                end else begin
                    init_cnt_d = init_cnt_q + ICW'(1);
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                if (pif.dbg_run) begin
                    state_d = ST_RUN;
                end else if (pif.dbg_step) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (!pif.dbg_run) begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                // A single step only completes once the pipeline actually moves.
                if (!mem_wait) begin
                    state_d = ST_HALT;
                end
            end
        endcase

        if (advance) begin
            stage_en = '1;
            if (mem_wait) begin
                stage_en.if_s  = 1'b0;
                stage_en.id_s  = 1'b0;
                stage_en.exe_s = 1'b0;
                stage_en.mem_s = 1'b0;
                stage_rst.wb_s = 1'b1;
                wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 8'd1;
                if (wait_cnt_d == WAIT_MAX) begin
                    mem_err_d = 1'b1;
                end
            end else if (pif.is_branch_mem) begin
                stage_rst.id_s  = 1'b1;
                stage_rst.exe_s = 1'b1;
                stage_rst.mem_s = 1'b1;
            end else if (load_use) begin
                stage_en.if_s   = 1'b0;
                stage_en.id_s   = 1'b0;
                stage_rst.exe_s = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (advance && (mem_wait || (!pif.is_branch_mem && load_use))) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (advance && !mem_wait && pif.is_branch_mem) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pif.stall_cnt = stall_cnt_q;
    assign pif.flush_cnt = flush_cnt_q;
`else
    assign pif.stall_cnt = '0;
    assign pif.flush_cnt = '0;
`endif

    assign pif.if_rst         = stage_rst.if_s;
    assign pif.id_rst         = stage_rst.id_s;
    assign pif.exe_rst        = stage_rst.exe_s;
    assign pif.mem_rst        = stage_rst.mem_s;
    assign pif.wb_rst         = stage_rst.wb_s;
    assign pif.if_en          = stage_en.if_s;
    assign pif.id_en          = stage_en.id_s;
    assign pif.exe_en         = stage_en.exe_s;
    assign pif.mem_en         = stage_en.mem_s;
    assign pif.wb_en          = stage_en.wb_s;
    assign pif.exe_fwd_a_ctrl = fwd_a;
    assign pif.exe_fwd_b_ctrl = fwd_b;
    assign pif.halted         = halted;
    assign pif.mem_err        = mem_err_q;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Hazard and sequencing controller for the 5-stage MIPS pipeline datapath. It drives the per-stage rst/en pairs and the EXE-entry forwarding selects. It handles load-use stalls, branch flushes, data-memory wait states and a debug run/halt/single-step FSM, and sits beside the instruction decoder in the CPU top.

Parameters:
RST_CYCLES, 4, cycles all stage resets are held after rst deasserts (≥1)
MEM_TIMEOUT, 255, max consecutive mem wait cycles before mem_err; 8-bit counter

Ports:
clk  in  1  main clock
rst  in  1  synchronous active-high reset
rs_used_id  in  1  instruction in ID reads rs (from decoder)
rt_used_id  in  1  instruction in ID reads rt
inst_data_id  in  32  instruction in ID; rs=[25:21], rt=[20:16]
regw_addr_exe  in  5  dest reg of EXE instruction
wb_wen_exe  in  1  EXE instruction writes a register
wb_data_src_exe  in  1  1 = EXE instruction is a load
regw_addr_mem  in  5  dest reg of MEM instruction
wb_wen_mem  in  1  MEM instruction writes a register
wb_data_src_mem  in  1  1 = MEM instruction is a load
is_branch_mem  in  1  jump/branch in MEM; PC redirects this edge
mem_req  in  1  mem_ren|mem_wen of MEM stage
mem_ack  in  1  data memory completes access this cycle
dbg_run  in  1  level: 1 = free run, 0 = halt
dbg_step  in  1  pulse: advance one cycle while halted
if_rst, id_rst, exe_rst, mem_rst, wb_rst  out  1 each  stage resets
if_en, id_en, exe_en, mem_en, wb_en  out  1 each  stage enables
exe_fwd_a_ctrl  out  2  rs forwarding select
exe_fwd_b_ctrl  out  2  rt forwarding select
halted  out  1  FSM in HALT
mem_err  out  1  sticky: memory wait exceeded MEM_TIMEOUT
stall_cnt  out  32  stall cycle count (see Optional Feature)
flush_cnt  out  32  flush count

Behaviour:
- Reset and clock: clk is the single clock. rst is synchronous and active-high.
- FSM states: INIT, RUN, HALT, STEP.
  - rst → INIT, counter cleared. All *_rst=1, all *_en=0, fwd=FWD_NO, halted=0, mem_err=0, counters=0.
  - INIT holds for RST_CYCLES cycles after rst falls, then goes to RUN if dbg_run, else HALT.
  - RUN → HALT when dbg_run=0. The cycle that samples dbg_run=0 still advances.
  - HALT: all en=0, all rst=0, halted=1. HALT → RUN when dbg_run=1. HALT → STEP on dbg_step (dbg_run wins if both are set).
  - STEP: one advance cycle, then HALT. If a mem wait freezes that cycle, stay in STEP until the pipeline advances.
- Advance-cycle control (RUN/STEP), in priority order; all en=1 and all rst=0 unless listed:
  1. Mem wait (mem_req & ~mem_ack): if/id/exe/mem en=0; wb_rst=1 (bubble into WB). Wait counter increments. When the counter reaches MEM_TIMEOUT, mem_err is set (sticky until rst); the freeze continues. The counter clears on any non-wait cycle.
  2. Branch flush (is_branch_mem): id_rst=exe_rst=mem_rst=1; IF loads the target. Penalty is 3 bubbles.
  3. Load-use: wb_wen_exe & wb_data_src_exe & regw_addr_exe≠0 & ((rs_used_id & rs==regw_addr_exe) | (rt_used_id & rt==regw_addr_exe)). Response: if_en=id_en=0, exe_rst=1. One bubble; next cycle resolves via FWD_MEM.
- Forwarding, per operand, combinational from the ID fields (fwd_a uses rs, fwd_b uses rt):
  - Operand unused, or its register is 0 → FWD_NO.
  - Else match EXE dest & wb_wen_exe & ~wb_data_src_exe → FWD_ALU_EXE.
  - Else match MEM dest & wb_wen_mem → FWD_MEM if wb_data_src_mem, else FWD_ALU_MEM.
  - Else FWD_NO.
  - EXE beats MEM.
  - A WB-stage producer is covered by the regfile write-through; no select is needed.
- Encoding: FWD_NO=0, FWD_ALU_EXE=1, FWD_ALU_MEM=2, FWD_MEM=3.
- Outputs are combinational from registered state plus inputs; zero added latency.
- rst mid-operation returns to INIT on the next edge regardless of state.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: stall_cnt increments on each load-use or mem-wait cycle in RUN/STEP. flush_cnt increments once per branch flush. Both are 32-bit, wrap at 2^32, and clear on rst.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Shared package/header: FWD_* encodings, FSM state encodings (INIT=0, RUN=1, HALT=2, STEP=3), GPR_ZERO.
- Sub-module fwd_sel: per-operand forwarding mux-select logic, instantiated twice (rs, rt).

Test Plan:
- rst 1 cycle, dbg_run=1 → *_rst=1 for 4 cycles after rst falls, then all en=1 and halted=0.
- lw $2 in EXE (regw_addr_exe=2, load), ID add reads rs=2 → cycle 1: if_en=id_en=0, exe_rst=1. Cycle 2: exe_fwd_a_ctrl=3.
- ALU producer $5 in EXE and ALU producer $5 in MEM, ID reads rt=5 → exe_fwd_b_ctrl=1. Same case with dest=0 → exe_fwd_b_ctrl=0.
- is_branch_mem=1 coincident with a load-use match → id/exe/mem_rst=1, if_en=1, no stall; flush_cnt +1.
- mem_req=1, mem_ack=0 for 300 cycles → pipeline frozen, wb_rst=1, mem_err set at wait cycle 255 and held.
- dbg_run=0, then dbg_step pulses 3× → exactly 3 advance cycles, halted=1 between them.
